usb_rx_bit_unstuff: RTL and testbench

Receiver-side bit unstuffer. Sits between the NRZI decoder and the CRC16/CRC5 decode stages. Consumes the NRZI-decoded serial bit stream of one packet (after SYNC, before EOP) and removes the zero stuffed after every run of MAX_ONES ones. Emits unstuffed bits with a qualifying strobe (bs_sending) and flags stuffing violations.

---
 rtl/usb_rx_bit_unstuff_pkg.sv | 14 +
 rtl/usb_rx_bit_unstuff_ones_run.sv | 32 +++
 rtl/usb_rx_bit_unstuff.sv | 108 ++++++++++
 tb/tb_usb_rx_bit_unstuff.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_bit_unstuff_pkg.sv
// Shared types and defaults for the USB receive bit-unstuff path.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DROP,
    ERROR
  } unstuff_state_t;

  localparam int USB_MAX_ONES = 6;
  localparam int USB_BITCNT_W = 16;

endpackage

// File: rtl/usb_rx_bit_unstuff_ones_run.sv
// Consecutive-ones counter; run_hit flags the bit that completes a run of MAX_ONES.
module usb_rx_ones_run
  import usb_rx_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic data_bit,
  input  logic valid,
  input  logic clear,
  output logic run_hit
);

  localparam int ONES_W = $clog2(MAX_ONES + 1);

  logic [ONES_W-1:0] ones;

  // Combinational so the FSM can enter DROP on the same edge the sixth one is accepted.
  assign run_hit = valid && data_bit && (ones == ONES_W'(MAX_ONES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ones <= '0;
    end else if (clear) begin
      ones <= '0;
    end else if (valid) begin
      ones <= data_bit ? ones + ONES_W'(1) : '0;
    end
  end

endmodule

// File: rtl/usb_rx_bit_unstuff.sv
// Receive bit unstuffer: drops the 0 after MAX_ONES ones, flags violations; 1-cycle latency.
// Optional USB_RX_UNSTUFF_STATS_EN adds stuff_cnt (stuffed bits removed this packet).
module usb_rx_bit_unstuff
  import usb_rx_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES,
  parameter int CNT_W    = USB_BITCNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             pkt_start,
  input  logic             pkt_end,
  output logic             out_bit,
  output logic             bs_sending,
  output logic             pkt_active,
  output logic             stuff_err,
  output logic [CNT_W-1:0] bit_cnt
`ifdef USB_RX_UNSTUFF_STATS_EN
  ,
  output logic [7:0]       stuff_cnt
`endif
);

  unstuff_state_t state, state_nxt;
  logic emit, drop_ok, violation;
  logic run_hit;
  logic ones_valid, ones_clear;

  assign ones_valid = (state == RUN) && in_valid && !pkt_start;
  assign ones_clear = pkt_start || ((state == DROP) && in_valid);

  usb_rx_ones_run #(.MAX_ONES(MAX_ONES)) u_ones_run (
    .clock    (clock),
    .reset_n  (reset_n),
    .data_bit (in_bit),
    .valid    (ones_valid),
    .clear    (ones_clear),
    .run_hit  (run_hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    drop_ok   = 1'b0;
    violation = 1'b0;
    case (state)
      RUN: begin
        if (in_valid) begin
          emit = 1'b1;
          if (run_hit) state_nxt = DROP;
        end
      end
      DROP: begin
        if (in_valid) begin
          if (in_bit) begin
            violation = 1'b1;
            state_nxt = ERROR;
          end else begin
            drop_ok   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      default: ;
    endcase
    // The bit arriving with pkt_end is still processed; only the next state is overridden.
    if (pkt_end) state_nxt = IDLE;
    if (pkt_start) begin
      state_nxt = RUN;
      emit      = 1'b0;
      drop_ok   = 1'b0;
      violation = 1'b0;
    end
  end

  assign pkt_active = (state == RUN) || (state == DROP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_bit    <= 1'b0;
      bs_sending <= 1'b0;
      stuff_err  <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      out_bit    <= emit & in_bit;
      bs_sending <= emit;
      stuff_err  <= violation;
      if (pkt_start)                  bit_cnt <= '0;
      else if (emit && bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

`ifdef USB_RX_UNSTUFF_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         stuff_cnt <= 8'd0;
    else if (pkt_start)                   stuff_cnt <= 8'd0;
    else if (drop_ok && stuff_cnt != 8'hFF) stuff_cnt <= stuff_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_usb_rx_bit_unstuff.sv
// Directed bench for usb_rx_bit_unstuff with a one-cycle-latency expectation queue.
module tb_usb_rx_bit_unstuff;

  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          pkt_start = 1'b0;
  logic          pkt_end = 1'b0;
  logic          out_bit, bs_sending, pkt_active, stuff_err;
  logic [CW-1:0] bit_cnt;
`ifdef USB_RX_UNSTUFF_STATS_EN
  logic [7:0]    stuff_cnt;
`endif

  usb_rx_bit_unstuff #(.MAX_ONES(6), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .pkt_start  (pkt_start),
    .pkt_end    (pkt_end),
    .out_bit    (out_bit),
    .bs_sending (bs_sending),
    .pkt_active (pkt_active),
    .stuff_err  (stuff_err),
    .bit_cnt    (bit_cnt)
`ifdef USB_RX_UNSTUFF_STATS_EN
    ,
    .stuff_cnt  (stuff_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic bs;
    logic b;
    logic err;
    logic act;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what the DUT must show after the edge, then compare.
  task automatic step(input logic v, input logic b, input logic st, input logic en,
                      input logic ebs, input logic eb, input logic eerr, input logic eact,
                      input string tag);
    exp_t e;
    in_valid  = v;
    in_bit    = b;
    pkt_start = st;
    pkt_end   = en;
    sb.push_back('{ebs, eb, eerr, eact});
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    pkt_start = 1'b0;
    pkt_end   = 1'b0;
    e = sb.pop_front();
    chk({tag, ".bs_sending"}, 32'(bs_sending), 32'(e.bs));
    if (e.bs) chk({tag, ".out_bit"}, 32'(out_bit), 32'(e.b));
    chk({tag, ".stuff_err"}, 32'(stuff_err), 32'(e.err));
    chk({tag, ".pkt_active"}, 32'(pkt_active), 32'(e.act));
  endtask

  task automatic start_pkt(input string tag);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic end_pkt(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Bits that must pass straight through, MSB of pat first.
  task automatic pass_bits(input logic [15:0] pat, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--)
      step(1'b1, pat[i], 1'b0, 1'b0, 1'b1, pat[i], 1'b0, 1'b1, $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.out_bit", 32'(out_bit), 0);
    chk("rst.bs_sending", 32'(bs_sending), 0);
    chk("rst.pkt_active", 32'(pkt_active), 0);
    chk("rst.stuff_err", 32'(stuff_err), 0);
    chk("rst.bit_cnt", 32'(bit_cnt), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // IDLE ignores valid bits
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_ignore");

    // Plain pass-through 10110010
    start_pkt("t1.start");
    chk("t1.bit_cnt_clr", 32'(bit_cnt), 0);
    pass_bits(16'b1011_0010, 8, "t1");
    chk("t1.bit_cnt", 32'(bit_cnt), 8);
    end_pkt("t1.end");
    chk("t1.bit_cnt_held", 32'(bit_cnt), 8);

    // 1111110 then 1: stuffed zero removed
    start_pkt("t2.start");
    pass_bits(16'b11_1111, 6, "t2.ones");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t2.drop");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "t2.after");
    chk("t2.bit_cnt", 32'(bit_cnt), 7);
`ifdef USB_RX_UNSTUFF_STATS_EN
    chk("t2.stuff_cnt", 32'(stuff_cnt), 1);
`endif
    end_pkt("t2.end");

    // 1111111: stuffing violation, then clean recovery
    start_pkt("t3.start");
    pass_bits(16'b11_1111, 6, "t3.ones");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3.viol");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t3.err_hold0");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t3.err_hold1");
    start_pkt("t3.restart");
    pass_bits(16'b01, 2, "t3.rec");
    chk("t3.bit_cnt", 32'(bit_cnt), 2);
    end_pkt("t3.end");

    // pkt_end on the stuffed-bit cycle: legal tail
    start_pkt("t4.start");
    pass_bits(16'b11_1111, 6, "t4.ones");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t4.end_on_stuff");
    chk("t4.bit_cnt", 32'(bit_cnt), 6);
`ifdef USB_RX_UNSTUFF_STATS_EN
    chk("t4.stuff_cnt", 32'(stuff_cnt), 1);
`endif
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4.idle_after");

    // Gap of 3 idle cycles inside a run of ones; the run count must survive it
    start_pkt("t5.start");
    pass_bits(16'b1_1111, 5, "t5.ones");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("t5.gap%0d", i));
    pass_bits(16'b1, 1, "t5.sixth");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5.drop");
    pass_bits(16'b1, 1, "t5.after");
    chk("t5.bit_cnt", 32'(bit_cnt), 7);
    end_pkt("t5.end");

    // Restart mid-packet clears the ones run: four ones after the restart all pass
    start_pkt("t6.start");
    pass_bits(16'b111, 3, "t6.pre");
    start_pkt("t6.restart");
    pass_bits(16'b1111, 4, "t6.post");
    chk("t6.bit_cnt", 32'(bit_cnt), 4);
    end_pkt("t6.end");

    // bit_cnt saturates instead of wrapping
    start_pkt("t7.start");
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'(i % 2), 1'b0, 1'b0, 1'b1, 1'(i % 2), 1'b0, 1'b1, $sformatf("t7.b%0d", i));
    chk("t7.bit_cnt_sat", 32'(bit_cnt), 31);
    end_pkt("t7.end");

    // Asynchronous reset while in DROP
    start_pkt("t8.start");
    pass_bits(16'b11_1111, 6, "t8.ones");
    reset_n = 1'b0;
    #1;
    chk("t8.rst.out_bit", 32'(out_bit), 0);
    chk("t8.rst.bs_sending", 32'(bs_sending), 0);
    chk("t8.rst.pkt_active", 32'(pkt_active), 0);
    chk("t8.rst.bit_cnt", 32'(bit_cnt), 0);
    #2;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t8.ign0");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t8.ign1");
    start_pkt("t8.restart");
    pass_bits(16'b10, 2, "t8.rec");
    chk("t8.bit_cnt", 32'(bit_cnt), 2);
    end_pkt("t8.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
